matmul_job_sequencer: RTL
=========================

Name: matmul_job_sequencer

Overview:
Job-level controller wrapped around sequential_matrix_multiplier. It stream-loads operand matrices A and B into two internal register banks and serves the multiplier's (i,j) operand reads from those banks. It holds the multiplier in reset until a job starts, collects the z_stb results into a result bank, and then streams the m×m product out row-major over a valid/ready port.

Parameters:
m, 4, matrix dimension (m×m, m ≥ 2)
IW, $clog2(m), row/column index width
TIMEOUT, 4096, watchdog limit in cycles; used only with MATMUL_TIMEOUT_EN

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
ld_valid  in  1  operand word valid
ld_ready  out  1  operand word accepted when ld_valid&&ld_ready
ld_sel  in  1  0 = word for A, 1 = word for B
ld_data  in  32  operand word, row-major order
start  in  1  job request (level-sampled)
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse when the product is complete
err  out  1  sticky error flag
mm_rst  out  1  active-high hold to the multiplier; low only in COMPUTE
mm_a_i, mm_a_j, mm_b_i, mm_b_j  in  IW  operand indices from the multiplier
mm_a_in, mm_b_in  out  32  A[a_i][a_j], B[b_i][b_j]; combinational read
mm_z_out  in  32  result word
mm_z_i, mm_z_j  in  IW  result indices
mm_z_stb  in  1  result strobe
rd_valid  out  1  result word valid
rd_ready  in  1  consumer ready
rd_data  out  32  result word, row-major
rd_last  out  1  high with the final (m-1,m-1) word

Behaviour:
- Reset values: all outputs 0 except mm_rst=1. All counters, full flags, the valid bitmap and err are cleared. State = IDLE.
- Reset mid-operation aborts the job immediately. Bank contents are don't-care; their full flags are cleared.
- FSM states:
  - IDLE: loading is allowed. start&&a_full&&b_full → COMPUTE; err is cleared on that start.
  - COMPUTE: mm_rst=0. On the last unique z_stb → READOUT, with done=1 for the following cycle.
  - READOUT: after the handshake on the rd_last word → IDLE. a_full and b_full are cleared on that transition.
- start in IDLE with either bank not full is ignored; no error.
- Loading:
  - ld_ready = (state==IDLE) && !full[ld_sel].
  - Each bank has its own write counter 0..m*m-1. The word at count m*m-1 sets full[ld_sel] and wraps the counter to 0.
- start and the final load handshake in the same cycle: start is evaluated against the registered flags, so it is ignored.
- Latency:
  - start accepted in cycle N → mm_rst low from N+1.
  - Last unique z_stb in cycle N → done and rd_valid high at N+1.
- Result capture:
  - On mm_z_stb in COMPUTE: write res[z_i][z_j] and set valid bit [z_i][z_j].
  - A strobe to an index whose valid bit is already set overwrites the data, sets err, and does not advance the unique count.
  - z_stb outside COMPUTE is ignored.
- Readout:
  - rd_data = res[r_i][r_j], starting at (0,0).
  - Indices advance row-major only on rd_valid&&rd_ready.
  - rd_data and rd_valid are stable while rd_ready is low.
- mm_a_in and mm_b_in are driven in every state; values are don't-care outside COMPUTE.
- Index arithmetic is unsigned IW-bit. The unique counter is 2*IW+1 bits wide so that m*m is representable.

Optional Feature:
MATMUL_TIMEOUT_EN.
- Defined: a cycle counter runs in COMPUTE, cleared on entry. If it reaches TIMEOUT before all m*m results arrive: mm_rst=1, err=1, return to IDLE without done, and clear a_full and b_full.
- Undefined: no counter exists, and COMPUTE waits indefinitely.

Decomposition:
- Package matmul_pkg: state enum (IDLE, COMPUTE, READOUT), the IW derivation function, the constant NUM_ELEMS = m*m, and word width 32.
- Sub-module matmul_operand_bank, instantiated three times (A, B, result). It is an m×m×32 register array with:
  - a sequential write port (we, wi, wj, wdata);
  - one combinational 2-D read port (ri, rj → rdata).

Test Plan:
- Identity product: m=4, load A = identity and B = 1..16 row-major, pulse start, behavioural multiplier emits results in arbitrary order → done one cycle after the 16th strobe; readout 1..16 with rd_last on 16.
- Premature start: start with only A loaded → stays IDLE, busy=0. Finish loading B, start again → COMPUTE next cycle, mm_rst falls.
- Load back-pressure: attempt a 17th A word → ld_ready=0 for ld_sel=0 while B words are still accepted. Same-cycle final B word plus start → start ignored.
- Duplicate strobe: model strobes (2,1) twice with 5 then 9 → err=1, done waits for the remaining 15 unique indices, readout at (2,1) returns 9.
- Readout stall: hold rd_ready low 3 cycles mid-stream at word 7 → rd_data steady, no word lost. rst low at word 10 → all outputs reset immediately, mm_rst=1.
- With MATMUL_TIMEOUT_EN and TIMEOUT=64: model stops after 10 results → exactly 64 cycles after start acceptance, err=1, IDLE, no done pulse.

Source files
------------

// File: rtl/matmul_job_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// matmul_pkg
// Shared types and constants for the matrix-multiply job sequencer.
//   state_t    : job FSM states (IDLE, COMPUTE, READOUT)
//   idx_width  : row/column index width for an m x m matrix (minimum 1 bit)
//   MAT_DIM    : default matrix dimension
//   NUM_ELEMS  : element count of a default-sized matrix
//   WORD_W     : operand/result word width
// -----------------------------------------------------------------------------
package matmul_pkg;

  localparam int WORD_W    = 32;
  localparam int MAT_DIM   = 4;
  localparam int NUM_ELEMS = MAT_DIM * MAT_DIM;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    READOUT = 2'd2
  } state_t;

  function automatic int idx_width(input int dim);
    return (dim <= 2) ? 1 : $clog2(dim);
  endfunction

endpackage

// File: rtl/matmul_operand_bank.sv
// -----------------------------------------------------------------------------
// matmul_operand_bank
// m x m array of 32-bit words. Used for operand A, operand B and the result.
// Ports:
//   clk              : clock, rising edge
//   we, wi, wj, wdata: synchronous write of wdata to element [wi][wj]
//   ri, rj, rdata    : combinational read of element [ri][rj]
// Contents are not reset; ownership of "which words are meaningful" lives in
// the sequencer's full flags and valid bitmap.
// -----------------------------------------------------------------------------
module matmul_operand_bank
  import matmul_pkg::*;
#(
  parameter int M  = MAT_DIM,
  parameter int IW = idx_width(M)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IW-1:0]     wi,
  input  logic [IW-1:0]     wj,
  input  logic [WORD_W-1:0] wdata,
  input  logic [IW-1:0]     ri,
  input  logic [IW-1:0]     rj,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [M][M];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wi][wj] <= wdata;
    end
  end

  assign rdata = mem[ri][rj];

endmodule

// File: rtl/matmul_job_sequencer.sv
// -----------------------------------------------------------------------------
// matmul_job_sequencer
// Job controller around a sequential matrix multiplier. Operands A and B are
// stream-loaded row-major into two banks, the multiplier reads them by (i,j),
// its strobed results are collected into a result bank, and the product is
// streamed out row-major on a valid/ready port.
//
// Optional build macro: MATMUL_TIMEOUT_EN adds a COMPUTE watchdog of TIMEOUT
// cycles that aborts the job (err=1, back to IDLE, no done pulse).
//
// Ports:
//   clk, rst                 : clock; asynchronous active-low reset
//   ld_valid/ld_ready/ld_sel/ld_data : operand load stream (sel 0=A, 1=B)
//   start                    : job request, sampled in IDLE
//   busy, done, err          : status (done is a one-cycle pulse, err sticky)
//   mm_rst                   : hold to the multiplier, low only in COMPUTE
//   mm_a_i/j, mm_b_i/j       : operand indices from the multiplier
//   mm_a_in, mm_b_in         : operand words back to the multiplier
//   mm_z_out/i/j/stb         : result word, indices and strobe
//   rd_valid/ready/data/last : result readout stream
// -----------------------------------------------------------------------------
module matmul_job_sequencer
  import matmul_pkg::*;
#(
  parameter int m       = MAT_DIM,
  parameter int IW      = idx_width(m),
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              ld_sel,
  input  logic [WORD_W-1:0] ld_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mm_rst,
  input  logic [IW-1:0]     mm_a_i,
  input  logic [IW-1:0]     mm_a_j,
  input  logic [IW-1:0]     mm_b_i,
  input  logic [IW-1:0]     mm_b_j,
  output logic [WORD_W-1:0] mm_a_in,
  output logic [WORD_W-1:0] mm_b_in,
  input  logic [WORD_W-1:0] mm_z_out,
  input  logic [IW-1:0]     mm_z_i,
  input  logic [IW-1:0]     mm_z_j,
  input  logic              mm_z_stb,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_last
);

  localparam int            CW        = 2 * IW + 1;
  localparam int            N_ELEMS   = m * m;
  localparam logic [IW-1:0] LAST_IDX  = IW'(m - 1);
  localparam logic [CW-1:0] LAST_ELEM = CW'(N_ELEMS - 1);

  state_t            state_reg, state_next;
  logic              done_reg, done_next;
  logic              err_reg;
  logic              out_en_reg;
  logic [CW-1:0]     uniq_reg;
  logic [IW-1:0]     r_i_reg, r_j_reg;

  logic [1:0]        full_vec;
  logic [IW-1:0]     bank_ri [2];
  logic [IW-1:0]     bank_rj [2];
  logic [WORD_W-1:0] bank_rdata [2];
  logic [WORD_W-1:0] res_rdata;
  logic [m-1:0]      valid_rows [m];

  logic ld_fire, start_accept, z_fire, z_dup, rd_fire, rd_last_int;
  logic last_unique, clr_full, timeout_hit;

  // ld_ready is held off until the first clock after reset release so that
  // every output except mm_rst reads 0 for the whole time reset is asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) out_en_reg <= 1'b0;
    else      out_en_reg <= 1'b1;
  end

  assign ld_ready     = out_en_reg && (state_reg == IDLE) && !full_vec[ld_sel];
  assign ld_fire      = ld_valid && ld_ready;
  // start is judged against the registered full flags, so a start in the
  // same cycle as the final load word is ignored.
  assign start_accept = (state_reg == IDLE) && start && full_vec[0] && full_vec[1];
  assign z_fire       = mm_z_stb && (state_reg == COMPUTE);
  assign z_dup        = valid_rows[mm_z_i][mm_z_j];
  assign last_unique  = z_fire && !z_dup && (uniq_reg == LAST_ELEM);
  assign rd_valid     = (state_reg == READOUT);
  assign rd_last_int  = (r_i_reg == LAST_IDX) && (r_j_reg == LAST_IDX);
  assign rd_last      = rd_valid && rd_last_int;
  assign rd_fire      = rd_valid && rd_ready;
  assign clr_full     = (rd_fire && rd_last_int) || timeout_hit;

  // ---------------------------------------------------------------------------
  // Operand banks A (gi=0) and B (gi=1), each with its own row-major write
  // position; the word landing on (m-1,m-1) marks the bank full and wraps.
  // ---------------------------------------------------------------------------
  assign bank_ri[0] = mm_a_i;
  assign bank_rj[0] = mm_a_j;
  assign bank_ri[1] = mm_b_i;
  assign bank_rj[1] = mm_b_j;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      logic [IW-1:0] wi_reg, wj_reg;
      logic          full_reg;
      logic          we;

      assign we = ld_fire && (ld_sel == 1'(gi));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          wi_reg   <= '0;
          wj_reg   <= '0;
          full_reg <= 1'b0;
        end else if (clr_full) begin
          full_reg <= 1'b0;
        end else if (we) begin
          if (wj_reg == LAST_IDX) begin
            wj_reg <= '0;
            if (wi_reg == LAST_IDX) begin
              wi_reg   <= '0;
              full_reg <= 1'b1;
            end else begin
              wi_reg <= wi_reg + IW'(1);
            end
          end else begin
            wj_reg <= wj_reg + IW'(1);
          end
        end
      end

      assign full_vec[gi] = full_reg;

      matmul_operand_bank #(.M(m), .IW(IW)) u_bank (
        .clk   (clk),
        .we    (we),
        .wi    (wi_reg),
        .wj    (wj_reg),
        .wdata (ld_data),
        .ri    (bank_ri[gi]),
        .rj    (bank_rj[gi]),
        .rdata (bank_rdata[gi])
      );
    end

    // Valid bitmap, one row per generate block; cleared when a job starts.
    for (gi = 0; gi < m; gi++) begin : g_valid
      logic [m-1:0] row_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          row_reg <= '0;
        end else if (start_accept) begin
          row_reg <= '0;
        end else if (z_fire && (mm_z_i == IW'(gi))) begin
          row_reg[mm_z_j] <= 1'b1;
        end
      end

      assign valid_rows[gi] = row_reg;
    end
  endgenerate

  // Result bank: written by multiplier strobes, read by the readout indices.
  matmul_operand_bank #(.M(m), .IW(IW)) u_res_bank (
    .clk   (clk),
    .we    (z_fire),
    .wi    (mm_z_i),
    .wj    (mm_z_j),
    .wdata (mm_z_out),
    .ri    (r_i_reg),
    .rj    (r_j_reg),
    .rdata (res_rdata)
  );

  // ---------------------------------------------------------------------------
  // Watchdog: COMPUTE lasts at most TIMEOUT cycles. The counter is 0 in the
  // first COMPUTE cycle, so the abort lands TIMEOUT edges after the accepting
  // edge. Completion on the final cycle takes priority over the abort.
  // ---------------------------------------------------------------------------
`ifdef MATMUL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      to_cnt_reg <= '0;
    else if (state_reg != COMPUTE) to_cnt_reg <= '0;
    else                           to_cnt_reg <= to_cnt_reg + TW'(1);
  end

  assign timeout_hit = (state_reg == COMPUTE) && !last_unique &&
                       (to_cnt_reg == TW'(TIMEOUT - 1));
`else
  // Never true; keeps TIMEOUT referenced in builds without the watchdog.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  // ---------------------------------------------------------------------------
  // Job FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_accept) state_next = COMPUTE;
      end
      COMPUTE: begin
        if (last_unique) begin
          state_next = READOUT;
          done_next  = 1'b1;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end
      READOUT: begin
        if (rd_fire && rd_last_int) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Job bookkeeping: error flag, unique-result count, readout position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_reg  <= 1'b0;
      uniq_reg <= '0;
      r_i_reg  <= '0;
      r_j_reg  <= '0;
    end else begin
      if (start_accept) begin
        err_reg  <= 1'b0;
        uniq_reg <= '0;
        r_i_reg  <= '0;
        r_j_reg  <= '0;
      end else begin
        if ((z_fire && z_dup) || timeout_hit) err_reg <= 1'b1;
        if (z_fire && !z_dup) uniq_reg <= uniq_reg + CW'(1);
        if (rd_fire) begin
          if (r_j_reg == LAST_IDX) begin
            r_j_reg <= '0;
            r_i_reg <= (r_i_reg == LAST_IDX) ? '0 : r_i_reg + IW'(1);
          end else begin
            r_j_reg <= r_j_reg + IW'(1);
          end
        end
      end
    end
  end

  assign busy    = (state_reg != IDLE);
  assign done    = done_reg;
  assign err     = err_reg;
  assign mm_rst  = (state_reg != COMPUTE);
  // Operand and result words are forced to 0 where they carry no meaning.
  assign mm_a_in = (state_reg == COMPUTE) ? bank_rdata[0] : '0;
  assign mm_b_in = (state_reg == COMPUTE) ? bank_rdata[1] : '0;
  assign rd_data = rd_valid ? res_rdata : '0;

endmodule
